// File: rtl/pattern_det_pkg.sv
// rtl/pattern_det_pkg.sv - shared types, constants and helpers for the pattern stream detector
// Case folding is used only when PATTERN_CASE_FOLD_EN is defined.
package pattern_det_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_TRACK = 2'd2
    } det_state_t;

    // Maps a-z onto A-Z by clearing bit 5; every other byte passes through unchanged.
    function automatic logic [CHAR_W-1:0] fold_case(input logic [CHAR_W-1:0] c);
        if (c >= 8'h61 && c <= 8'h7a) begin
            return {c[7:6], 1'b0, c[4:0]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pattern_lane_cmp.sv
// rtl/pattern_lane_cmp.sv - per-lane character compare with lowest-lane priority select
// Compares case-insensitively for letters when PATTERN_CASE_FOLD_EN is defined.
module pattern_lane_cmp
    import pattern_det_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES*CHAR_W-1:0] data,
    input  logic [CHAR_W-1:0]       pat,
    output logic                    hit,
    output logic [CHAR_W-1:0]       chr
);

    function automatic logic chars_equal(input logic [CHAR_W-1:0] a, input logic [CHAR_W-1:0] b);
`ifdef PATTERN_CASE_FOLD_EN
        return fold_case(a) == fold_case(b);
`else
        return a == b;
`endif
    endfunction

    // Scan from the top lane down so the lowest matching lane is the one left standing.
    always_comb begin
        hit = 1'b0;
        chr = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (chars_equal(data[i*CHAR_W +: CHAR_W], pat)) begin
                hit = 1'b1;
                chr = data[i*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: rtl/pattern_stream_detector.sv
// rtl/pattern_stream_detector.sv - multi-lane streaming pattern matcher with saturating match counter
// Optional case-insensitive letter matching is enabled by defining PATTERN_CASE_FOLD_EN.
module pattern_stream_detector
    import pattern_det_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [LANES*CHAR_W-1:0]      in_data,
    input  logic                         pat_wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]   pat_wr_addr,
    input  logic [CHAR_W-1:0]            pat_wr_data,
    input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
    output logic                         out_valid,
    output logic [CHAR_W-1:0]            out_char,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int AW    = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [CHAR_W-1:0] pat_mem [MAX_LEN];

    det_state_t        state, state_d;
    logic [AW-1:0]     idx, idx_d;
    logic [LEN_W-1:0]  len_q;
    logic              out_valid_d, match_d;
    logic [CHAR_W-1:0] out_char_d;
    logic [CNT_W-1:0]  cnt_d;

    logic              hit_cur, hit_first;
    logic [CHAR_W-1:0] char_cur, char_first;
    logic              len_ok, restart, hit_any, is_last;
    logic [AW-1:0]     cmp_idx;
    logic [CHAR_W-1:0] hit_char;

    // Pattern storage deliberately survives reset so software need not reload it.
    always_ff @(posedge clk) begin
        if (pat_wr_en) begin
            pat_mem[pat_wr_addr] <= pat_wr_data;
        end
    end

    pattern_lane_cmp #(.LANES(LANES)) u_cmp_cur (
        .data (in_data),
        .pat  (pat_mem[idx]),
        .hit  (hit_cur),
        .chr  (char_cur)
    );

    pattern_lane_cmp #(.LANES(LANES)) u_cmp_first (
        .data (in_data),
        .pat  (pat_mem[0]),
        .hit  (hit_first),
        .chr  (char_first)
    );

    assign len_ok   = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    assign restart  = (state == ST_TRACK) && !hit_cur && hit_first;
    assign hit_any  = hit_cur || restart;
    assign cmp_idx  = hit_cur ? idx : '0;
    assign hit_char = hit_cur ? char_cur : char_first;
    assign is_last  = (LEN_W'(cmp_idx) == pat_len - LEN_W'(1));

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        out_valid_d = 1'b0;
        out_char_d  = '0;
        match_d     = 1'b0;
        cnt_d       = match_cnt;
        case (state)
            ST_IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (len_ok) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT, ST_TRACK: begin
                if (!len_ok) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (pat_wr_en || (pat_len != len_q)) begin
                    // Pattern content or length changed underneath a partial match.
                    state_d = ST_HUNT;
                    idx_d   = '0;
                end else if (in_valid) begin
                    if (hit_any) begin
                        out_valid_d = 1'b1;
                        out_char_d  = hit_char;
                        if (is_last) begin
                            match_d = 1'b1;
                            state_d = ST_HUNT;
                            idx_d   = '0;
                            if (match_cnt != '1) begin
                                cnt_d = match_cnt + CNT_W'(1);
                            end
                        end else begin
                            state_d = ST_TRACK;
                            idx_d   = cmp_idx + AW'(1);
                        end
                    end else begin
                        state_d = ST_HUNT;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_char  <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            len_q     <= pat_len;
            out_valid <= out_valid_d;
            out_char  <= out_char_d;
            match     <= match_d;
            match_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pattern_stream_detector.sv
// tb/tb_pattern_stream_detector.sv - table-driven self-checking bench for pattern_stream_detector
// Expected values follow PATTERN_CASE_FOLD_EN when it is defined for the build.
module tb_pattern_stream_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        pat_wr_en;
    logic [3:0]  pat_wr_addr;
    logic [7:0]  pat_wr_data;
    logic [4:0]  pat_len;
    logic        out_valid;
    logic [7:0]  out_char;
    logic        match;
    logic [7:0]  match_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [7:0] l0;
        logic [7:0] l1;
        logic       ev;
        logic [7:0] ec;
        logic       em;
        int         ecnt;
    } vec_t;

    vec_t  tbl[$];
    string pat_s = "ILOVEYOU";

    pattern_stream_detector #(.LANES(2), .MAX_LEN(16), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .pat_wr_en   (pat_wr_en),
        .pat_wr_addr (pat_wr_addr),
        .pat_wr_data (pat_wr_data),
        .pat_len     (pat_len),
        .out_valid   (out_valid),
        .out_char    (out_char),
        .match       (match),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] l0, input logic [7:0] l1,
                                input logic ev, input logic [7:0] ec, input logic em, input int ecnt);
        vec_t e;
        e.v = v; e.l0 = l0; e.l1 = l1; e.ev = ev; e.ec = ec; e.em = em; e.ecnt = ecnt;
        tbl.push_back(e);
    endfunction

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            in_valid = tbl[i].v;
            in_data  = {tbl[i].l1, tbl[i].l0};
            @(negedge clk);
            chk($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("%s[%0d].out_char", tag, i), 32'(out_char), 32'(tbl[i].ec));
            chk($sformatf("%s[%0d].match", tag, i), 32'(match), 32'(tbl[i].em));
            chk($sformatf("%s[%0d].match_cnt", tag, i), 32'(match_cnt), 32'(tbl[i].ecnt));
        end
        in_valid = 1'b0;
        tbl.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load_pattern(input string s, input logic [4:0] len);
        for (int i = 0; i < s.len(); i++) begin
            pat_wr_en   = 1'b1;
            pat_wr_addr = 4'(i);
            pat_wr_data = s[i];
            @(negedge clk);
        end
        pat_wr_en = 1'b0;
        pat_len   = len;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        string s;
        int    pulses;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0; pat_len = 5'd8;

        @(negedge clk);
        chk("reset.out_valid", 32'(out_valid), 0);
        chk("reset.out_char", 32'(out_char), 0);
        chk("reset.match", 32'(match), 0);
        chk("reset.match_cnt", 32'(match_cnt), 0);
        do_reset();
        load_pattern(pat_s, 5'd8);

        // Single-lane match, then a partial match interrupted by reset.
        for (int i = 0; i < 8; i++) add(1, pat_s[i], "Z", 1, pat_s[i], i == 7, (i == 7) ? 1 : 0);
        add(0, "I", "I", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, pat_s[i], "Z", 1, pat_s[i], 0, 1);
        run_table("single");
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 0);
        chk("midrst.match", 32'(match), 0);
        chk("midrst.match_cnt", 32'(match_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 3; i < 8; i++) add(1, pat_s[i], "Z", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, pat_s[i], "Z", 1, pat_s[i], i == 7, (i == 7) ? 1 : 0);
        run_table("postrst");

        // Cross-lane, back to back and then with idle gaps.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) add(1, pat_s[i], "Q", 1, pat_s[i], i == 7, (i == 7) ? 1 : 0);
            else            add(1, "Q", pat_s[i], 1, pat_s[i], i == 7, (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) add(1, pat_s[i], "Q", 1, pat_s[i], i == 7, (i == 7) ? 2 : 1);
            else            add(1, "Q", pat_s[i], 1, pat_s[i], i == 7, (i == 7) ? 2 : 1);
            add(0, pat_s[i], pat_s[i], 0, 0, 0, (i == 7) ? 2 : 1);
        end
        run_table("cross");

        // Restart on miss, then a plain miss while tracking.
        do_reset();
        s = "ILILOVEYOU";
        for (int i = 0; i < 10; i++) add(1, s[i], "Z", 1, s[i], i == 9, (i == 9) ? 1 : 0);
        add(1, "I", "Z", 1, "I", 0, 1);
        add(1, "X", "Z", 0, 0, 0, 1);
        add(1, "L", "Z", 0, 0, 0, 1);
        run_table("restart");

        // Mixed-case stream and lowest-lane priority.
        do_reset();
        s = "iLoveYou";
`ifdef PATTERN_CASE_FOLD_EN
        for (int i = 0; i < 8; i++) add(1, s[i], "Z", 1, s[i], i == 7, (i == 7) ? 1 : 0);
        add(1, "i", "I", 1, "i", 0, 1);
        add(1, "X", "l", 1, "l", 0, 1);
`else
        for (int i = 0; i < 8; i++) add(1, s[i], "Z", 0, 0, 0, 0);
        add(1, "i", "I", 1, "I", 0, 0);
        add(1, "X", "l", 0, 0, 0, 0);
`endif
        run_table("case");

        // Counter saturation with a one-character pattern.
        do_reset();
        load_pattern("A", 5'd1);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data  = {8'h5a, 8'h41};
            @(negedge clk);
            if (match) pulses++;
            if (i == 253) chk("sat.cnt_254", 32'(match_cnt), 254);
        end
        in_valid = 1'b0;
        chk("sat.pulses", 32'(pulses), 300);
        chk("sat.match_cnt", 32'(match_cnt), 255);

        // Pattern write aborts a partial match at idx=5.
        do_reset();
        load_pattern(pat_s, 5'd8);
        for (int i = 0; i < 5; i++) add(1, pat_s[i], "Z", 1, pat_s[i], 0, 0);
        run_table("abort_pre");
        in_valid = 1'b1; in_data = {8'h5a, 8'h59};
        pat_wr_en = 1'b1; pat_wr_addr = 4'd0; pat_wr_data = "I";
        @(negedge clk);
        pat_wr_en = 1'b0; in_valid = 1'b0;
        chk("abort.out_valid", 32'(out_valid), 0);
        chk("abort.match", 32'(match), 0);
        for (int i = 5; i < 8; i++) add(1, pat_s[i], "Z", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, pat_s[i], "Z", 1, pat_s[i], i == 7, (i == 7) ? 1 : 0);
        run_table("abort_post");

        // Out-of-range pattern lengths keep the detector idle.
        pat_len = 5'd0;
        @(negedge clk);
        add(1, "I", "I", 0, 0, 0, 0);
        run_table("len0");
        pat_len = 5'd17;
        @(negedge clk);
        add(1, "I", "I", 0, 0, 0, 0);
        run_table("len17");
        pat_len = 5'd8;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) add(1, pat_s[i], "Z", 1, pat_s[i], i == 7, (i == 7) ? 1 : 0);
        run_table("relen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_stream_detector.md
PATTERN_STREAM_DETECTOR -- requirements
Module: pattern_stream_detector

Interface
REQ-001 SHALL have parameter LANES, default 2, the number of parallel character lanes.
REQ-002 SHALL have parameter MAX_LEN, default 16, the pattern storage depth in characters.
REQ-003 SHALL have parameter CNT_W, default 8, the match counter width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in_data is valid this cycle.
REQ-007 SHALL have port in_data, input, LANES*8 bits, one ASCII character per lane, with lane 0 in bits [7:0].
REQ-008 SHALL have port pat_wr_en, input, 1 bit, the pattern RAM write strobe.
REQ-009 SHALL have port pat_wr_addr, input, clog2(MAX_LEN) bits, the pattern character index.
REQ-010 SHALL have port pat_wr_data, input, 8 bits, the pattern character.
REQ-011 SHALL have port pat_len, input, clog2(MAX_LEN+1) bits, the active pattern length.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning a character advanced the match.
REQ-013 SHALL have port out_char, output, 8 bits, the advancing character exactly as received.
REQ-014 SHALL have port match, output, 1 bit, a one-cycle pulse on pattern completion.
REQ-015 SHALL have port match_cnt, output, CNT_W bits, the count of completed matches.

Function
REQ-016 SHALL hold a match index idx and use a 3-state FSM: IDLE (disabled), HUNT (idx=0), TRACK (idx>0).
REQ-017 SHALL stay in IDLE, with all outputs low, while pat_len is 0 or greater than MAX_LEN; a valid pat_len SHALL move the FSM to HUNT the next cycle.
REQ-018 SHALL register a hit when in_valid=1 and any lane equals pat[idx]; the lowest-numbered hitting lane SHALL supply out_char.
REQ-019 SHALL, on a hit, assert out_valid and drive out_char exactly 1 cycle after the input, then increment idx.
REQ-020 SHALL, on a hit at idx=pat_len-1, pulse match for 1 cycle (coincident with out_valid), return idx to 0 and go to HUNT, so matches do not overlap.
REQ-021 SHALL, on a miss in TRACK, reset idx to 0 and re-compare the same input against pat[0] in that cycle; a hit there SHALL set idx=1.
REQ-022 SHALL hold idx and state, and drive out_valid=0, while in_valid=0.
REQ-023 SHALL increment match_cnt on each match and saturate it at 2^CNT_W-1.
REQ-024 SHALL let pat_wr_en write the pattern RAM in any state; any write SHALL abort a partial match (idx=0, HUNT) with no match pulse that cycle.
REQ-025 SHALL let a pat_len change take effect the next cycle and force idx=0.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear idx, out_valid, out_char, match and match_cnt to 0 and put the FSM in IDLE.
REQ-027 SHALL NOT clear pattern RAM contents on reset.
REQ-028 SHALL abort any partial match when reset is asserted mid-operation, with no match pulse emitted.

Configuration
REQ-029 SHALL, with macro PATTERN_CASE_FOLD_EN defined, compare ASCII letters A-Z and a-z case-insensitively (other bytes exact), while out_char still reports the lane's original byte.
REQ-030 SHALL, without PATTERN_CASE_FOLD_EN, use exact 8-bit equality only.

Structure
REQ-031 SHALL place the FSM state enum, CHAR_W=8 and the case-fold function in package pattern_det_pkg.
REQ-032 SHALL implement the per-lane comparison plus lowest-lane priority encoder (outputs hit, char) as sub-module pattern_lane_cmp, instantiated once for the pat[idx] compare and once for the pat[0] restart compare.

Verification
REQ-033 SHALL check reset: rst=1 mid-TRACK (idx=3) -> out_valid=0, match=0, match_cnt=0 immediately; after release, idx=0.
REQ-034 SHALL check a single-lane match: pattern "ILOVEYOU", pat_len=8, lane0 carries I,L,O,V,E,Y,O,U on consecutive cycles and lane1 'Z' -> out_valid for 8 cycles, each 1 cycle later, then match pulse with 'U' and match_cnt=1.
REQ-035 SHALL check a cross-lane match: the same pattern with letters alternating between lane0 and lane1 and the other lane 'Q' -> match_cnt=1; with gaps of in_valid=0 between letters -> still 1 match.
REQ-036 SHALL check restart: stream I,L,I,L,O,V,E,Y,O,U -> miss at the third char re-hits pat[0], then exactly 1 match, on the 10th char.
REQ-037 SHALL check case: stream "iLoveYou" -> match only when PATTERN_CASE_FOLD_EN is defined, with out_char='i' first; without the macro, no match.
REQ-038 SHALL check saturation and abort: 300 matches with CNT_W=8 -> match_cnt=255; pat_wr_en at idx=5 -> idx=0 and no match pulse.
